// File: rtl/da_platform_pkg.sv
// Shared types and constants for the DA2 sample scheduler.
// FSM encoding, frame geometry and default pacing divider.
package da_platform_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } dac_state_t;

    localparam int FRAME_BYTES    = 4;
    localparam int SAMPLE_W       = 12;
    localparam int FRAME_W        = 2 * SAMPLE_W;
    localparam int DEF_SAMPLE_DIV = 1134;
    localparam int BUSY_TIMEOUT   = 4;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous frame FIFO with combinational head and level count.
// A pop in the same cycle as a push frees a slot even when full.
module sample_fifo
    import da_platform_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic               clk0,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic [FRAME_W-1:0] wdata,
    output logic [FRAME_W-1:0] rdata,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        level
);

    logic [FRAME_W-1:0] mem [2**AW];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(2**AW));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk0) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally; level tracks net push/pop.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Assembles USB bytes into stereo frames and paces them to the DA2
// driver at a fixed sample tick, flagging underrun, overrun and late.
module dac_sample_scheduler
    import da_platform_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int FIFO_AW    = 4
) (
    input  logic                clk0,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [7:0]          usb_data,
    input  logic                usb_active,
    input  logic                dac_done,
    output logic                dac_start,
    output logic [SAMPLE_W-1:0] dac_data1,
    output logic [SAMPLE_W-1:0] dac_data2,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                underrun,
    output logic                overrun,
    output logic                late,
    input  logic                clear_flags
);

    logic [1:0]         byte_idx;
    logic [3:0]         ch1_lo;
    logic [7:0]         ch1_hi;
    logic [3:0]         ch2_lo;
    logic               push;
    logic [FRAME_W-1:0] wdata;
    logic [FRAME_W-1:0] rdata;
    logic               full;
    logic               empty;
    logic [15:0]        tick_cnt;
    logic               tick;
    dac_state_t         state;
    dac_state_t         state_n;
    logic [1:0]         busy_cnt;
    logic               pop;
    logic               set_late;
    logic               set_under;
    logic               set_over;

    assign push     = usb_active && (byte_idx == 2'(FRAME_BYTES - 1));
    assign wdata    = {usb_data, ch2_lo, ch1_hi, ch1_lo};
    assign set_over = push & full & ~pop;
    assign dac_start = (state == ST_START);

    sample_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk0    (clk0),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (wdata),
        .rdata   (rdata),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    // Byte assembly; the last byte is used live at the push edge.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx <= '0;
            ch1_lo   <= '0;
            ch1_hi   <= '0;
            ch2_lo   <= '0;
        end else if (usb_active) begin
            byte_idx <= byte_idx + 1'b1;
            unique case (byte_idx)
                2'd0:    ch1_lo <= usb_data[3:0];
                2'd1:    ch1_hi <= usb_data;
                2'd2:    ch2_lo <= usb_data[3:0];
                default: ;
            endcase
        end
    end

    // Sample-rate divider with a registered one-cycle tick on wrap.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (!enable) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == 16'(SAMPLE_DIV - 1)) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            tick     <= 1'b0;
        end
    end

    // State, busy timeout, sample hold registers and sticky flags.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            busy_cnt  <= '0;
            dac_data1 <= '0;
            dac_data2 <= '0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
            late      <= 1'b0;
        end else begin
            state    <= state_n;
            busy_cnt <= (state == ST_WAIT_BUSY) ? busy_cnt + 1'b1 : '0;
            if (pop) begin
                dac_data1 <= rdata[SAMPLE_W-1:0];
                dac_data2 <= rdata[FRAME_W-1:SAMPLE_W];
            end
            underrun <= (underrun & ~clear_flags) | set_under;
            overrun  <= (overrun & ~clear_flags) | set_over;
            late     <= (late & ~clear_flags) | set_late;
        end
    end

    // Next state, pop decision and flag events.
    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        set_late  = 1'b0;
        set_under = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (tick) begin
                    set_under = empty;
                    set_late  = ~dac_done;
                    if (!empty && dac_done) begin
                        pop     = 1'b1;
                        state_n = ST_START;
                    end
                end
            end
            ST_START: begin
                set_late = tick;
                state_n  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                set_late = tick;
                if (!dac_done) begin
                    state_n = ST_WAIT_IDLE;
                end else if (busy_cnt == 2'(BUSY_TIMEOUT - 1)) begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                set_late = tick;
                if (dac_done) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench for dac_sample_scheduler with a simple DAC model.
// Expected samples are queued at stimulus time and checked on dac_start.
module tb_dac_sample_scheduler;

    logic        clk0 = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [7:0]  usb_data;
    logic        usb_active;
    logic        dac_done;
    logic        dac_start;
    logic [11:0] dac_data1;
    logic [11:0] dac_data2;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic        overrun;
    logic        late;
    logic        clear_flags;

    typedef struct packed {
        logic [11:0] d1;
        logic [11:0] d2;
    } exp_t;

    exp_t exp_q[$];
    int   vectors   = 0;
    int   errors    = 0;
    int   start_cnt = 0;
    int   busy_len  = 16;

    always #5 clk0 = ~clk0;

    dac_sample_scheduler #(.SAMPLE_DIV(8), .FIFO_AW(2)) dut (
        .clk0        (clk0),
        .reset_n     (reset_n),
        .enable      (enable),
        .usb_data    (usb_data),
        .usb_active  (usb_active),
        .dac_done    (dac_done),
        .dac_start   (dac_start),
        .dac_data1   (dac_data1),
        .dac_data2   (dac_data2),
        .fifo_level  (fifo_level),
        .underrun    (underrun),
        .overrun     (overrun),
        .late        (late),
        .clear_flags (clear_flags)
    );

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every start, checks pulse width.
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk0);
            if (!reset_n) begin
                prev = 1'b0;
            end else begin
                if (prev) check("start_width", int'(dac_start), 0);
                if (dac_start) begin
                    start_cnt++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_start: got start, expected none");
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("data1", int'(dac_data1), int'(e.d1));
                        check("data2", int'(dac_data2), int'(e.d2));
                    end
                end
                prev = dac_start;
            end
        end
    end

    // DAC driver model: goes busy after a start for busy_len cycles.
    initial begin
        dac_done = 1'b1;
        forever begin
            @(negedge clk0);
            if (dac_start && reset_n) begin
                dac_done = 1'b0;
                repeat (busy_len) @(negedge clk0);
                dac_done = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [11:0] e1, input logic [11:0] e2,
                              input bit plays);
        logic [7:0] b [4];
        exp_t e;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        e.d1 = e1;
        e.d2 = e2;
        if (plays) exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk0);
            usb_data   = b[i];
            usb_active = 1'b1;
        end
        @(negedge clk0);
        usb_active = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n;
        n = 0;
        while (start_cnt < target && n < budget) begin
            @(negedge clk0);
            n++;
        end
        check("start_count", start_cnt, target);
    endtask

    task automatic pulse_clear();
        @(negedge clk0);
        clear_flags = 1'b1;
        @(negedge clk0);
        clear_flags = 1'b0;
    endtask

    task automatic wait_done_high(input int budget);
        int n;
        n = 0;
        while (!dac_done && n < budget) begin
            @(negedge clk0);
            n++;
        end
        check("dac_done_idle", int'(dac_done), 1);
    endtask

    initial begin
        int base;
        reset_n     = 1'b0;
        enable      = 1'b0;
        usb_data    = '0;
        usb_active  = 1'b0;
        clear_flags = 1'b0;
        repeat (3) @(negedge clk0);
        check("rst_start", int'(dac_start), 0);
        check("rst_data1", int'(dac_data1), 0);
        check("rst_data2", int'(dac_data2), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_flags", int'({underrun, overrun, late}), 0);
        reset_n = 1'b1;

        // Basic frame, then upper-nibble masking.
        enable = 1'b1;
        send_frame(8'h0A, 8'hBC, 8'h05, 8'h67, 12'hBCA, 12'h675, 1'b1);
        wait_starts(1, 100);
        repeat (30) @(negedge clk0);
        send_frame(8'hFA, 8'h12, 8'hF3, 8'h45, 12'h12A, 12'h453, 1'b1);
        wait_starts(2, 100);
        repeat (30) @(negedge clk0);

        // Underrun: empty FIFO across three ticks.
        enable = 1'b0;
        pulse_clear();
        @(negedge clk0);
        check("under_cleared", int'(underrun), 0);
        enable = 1'b1;
        repeat (28) @(negedge clk0);
        check("underrun_set", int'(underrun), 1);
        check("under_no_start", start_cnt, 2);
        check("under_hold1", int'(dac_data1), 12'h12A);
        check("under_hold2", int'(dac_data2), 12'h453);

        // Overrun: five frames into a four-deep FIFO, no playback.
        enable = 1'b0;
        pulse_clear();
        send_frame(8'h01, 8'h23, 8'h45, 8'h67, 12'h231, 12'h675, 1'b1);
        send_frame(8'h89, 8'hAB, 8'hCD, 8'hEF, 12'hAB9, 12'hEFD, 1'b1);
        send_frame(8'h10, 8'h20, 8'h30, 8'h40, 12'h200, 12'h400, 1'b1);
        send_frame(8'h0F, 8'hFF, 8'hF0, 8'h00, 12'hFFF, 12'h000, 1'b1);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 12'h000, 12'h000, 1'b0);
        @(negedge clk0);
        check("ovr_level", int'(fifo_level), 4);
        check("overrun_set", int'(overrun), 1);
        pulse_clear();
        check("ovr_cleared", int'(overrun), 0);
        enable = 1'b1;
        wait_starts(6, 400);
        repeat (2) @(negedge clk0);
        check("ovr_drained", int'(fifo_level), 0);

        // Late: DAC busy across a tick; only one frame consumed.
        enable = 1'b0;
        wait_done_high(60);
        repeat (5) @(negedge clk0);
        send_frame(8'h02, 8'h46, 8'h08, 8'hAC, 12'h462, 12'hAC8, 1'b1);
        send_frame(8'h0D, 8'hE0, 8'h0B, 8'hF1, 12'hE0D, 12'hF1B, 1'b1);
        pulse_clear();
        check("late_level0", int'(fifo_level), 2);
        busy_len = 20;
        base = start_cnt;
        enable = 1'b1;
        wait_starts(base + 1, 60);
        repeat (12) @(negedge clk0);
        enable = 1'b0;
        check("late_set", int'(late), 1);
        check("late_one_start", start_cnt, base + 1);
        check("late_level1", int'(fifo_level), 1);

        // Reset during WAIT_IDLE with three frames buffered.
        wait_done_high(60);
        repeat (5) @(negedge clk0);
        busy_len = 60;
        base = start_cnt;
        enable = 1'b1;
        wait_starts(base + 1, 60);
        enable = 1'b0;
        send_frame(8'h11, 8'h11, 8'h11, 8'h11, 12'h000, 12'h000, 1'b0);
        send_frame(8'h22, 8'h22, 8'h22, 8'h22, 12'h000, 12'h000, 1'b0);
        send_frame(8'h33, 8'h33, 8'h33, 8'h33, 12'h000, 12'h000, 1'b0);
        check("pre_rst_level", int'(fifo_level), 3);
        @(negedge clk0);
        usb_data   = 8'h55;
        usb_active = 1'b1;
        @(negedge clk0);
        usb_active = 1'b0;
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_start", int'(dac_start), 0);
        check("arst_data1", int'(dac_data1), 0);
        check("arst_data2", int'(dac_data2), 0);
        check("arst_level", int'(fifo_level), 0);
        check("arst_flags", int'({underrun, overrun, late}), 0);
        repeat (2) @(negedge clk0);
        reset_n = 1'b1;
        wait_done_high(100);
        busy_len = 16;
        repeat (3) @(negedge clk0);
        pulse_clear();
        base = start_cnt;
        send_frame(8'h3C, 8'h9D, 8'h7E, 8'h21, 12'h9DC, 12'h21E, 1'b1);
        check("post_rst_level", int'(fifo_level), 1);
        enable = 1'b1;
        wait_starts(base + 1, 100);
        enable = 1'b0;
        repeat (30) @(negedge clk0);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
